// File: rtl/axi_sram_slave_if.sv
// AXI4 slave-side channel bundle for the SRAM slave: AR, AW, W, B and R channels.
interface axi_sram_slave_if #(
  parameter int ID_BITS = 8
);
  logic [ID_BITS-1:0] ARID_S;
  logic [31:0]        ARADDR_S;
  logic [3:0]         ARLEN_S;
  logic [2:0]         ARSIZE_S;
  logic [1:0]         ARBURST_S;
  logic               ARVALID_S;
  logic               ARREADY_S;

  logic [ID_BITS-1:0] AWID_S;
  logic [31:0]        AWADDR_S;
  logic [3:0]         AWLEN_S;
  logic [2:0]         AWSIZE_S;
  logic [1:0]         AWBURST_S;
  logic               AWVALID_S;
  logic               AWREADY_S;

  logic [31:0]        WDATA_S;
  logic [3:0]         WSTRB_S;
  logic               WLAST_S;
  logic               WVALID_S;
  logic               WREADY_S;

  logic [ID_BITS-1:0] BID_S;
  logic [1:0]         BRESP_S;
  logic               BVALID_S;
  logic               BREADY_S;

  logic [ID_BITS-1:0] RID_S;
  logic [31:0]        RDATA_S;
  logic [1:0]         RRESP_S;
  logic               RLAST_S;
  logic               RVALID_S;
  logic               RREADY_S;

  modport master (
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S,
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  AWREADY_S,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    input  WREADY_S,
    input  BID_S, BRESP_S, BVALID_S,
    output BREADY_S,
    input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output RREADY_S
  );

  modport slave (
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S,
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output AWREADY_S,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    output WREADY_S,
    output BID_S, BRESP_S, BVALID_S,
    input  BREADY_S,
    output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input  RREADY_S
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave terminating one interconnect port onto a single-port synchronous
// SRAM. One transaction at a time, INCR/FIXED bursts, byte strobes, and
// round-robin arbitration between read and write address channels.
module axi_sram_slave #(
  parameter int ID_BITS   = 8,
  parameter int ADDR_BITS = 14
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axi_sram_slave_if.slave      s_axi,
  output logic                 sram_cs,
  output logic [3:0]           sram_we,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [31:0]          sram_wdata,
  input  logic [31:0]          sram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t               r_state;
  logic                 r_lastWasWrite;
  logic                 r_fixed;
  logic                 r_err;
  logic [ID_BITS-1:0]   r_id;
  logic [ADDR_BITS-1:0] r_addr;
  logic [3:0]           r_len;
  logic [4:0]           r_beat;

  logic                 w_idle;
  logic                 w_grantRd;
  logic                 w_grantWr;
  logic                 w_rValid;
  logic                 w_wReady;
  logic                 w_bValid;
  logic                 w_wHs;
  logic                 w_inRange;
  logic                 w_lastBeat;
  logic                 w_sramWr;
  logic [ADDR_BITS-1:0] w_nextAddr;
  logic                 w_unused;

  // Arbitration and handshake decode; everything is forced quiet while reset is asserted
  always_comb begin
    w_idle     = (r_state == IDLE) && !ARESET;
    w_grantRd  = w_idle && s_axi.ARVALID_S && (!s_axi.AWVALID_S || r_lastWasWrite);
    w_grantWr  = w_idle && s_axi.AWVALID_S && (!s_axi.ARVALID_S || !r_lastWasWrite);
    w_rValid   = (r_state == RD_DATA) && !ARESET;
    w_wReady   = (r_state == WR_DATA) && !ARESET;
    w_bValid   = (r_state == WR_RESP) && !ARESET;
    w_wHs      = w_wReady && s_axi.WVALID_S;
    w_inRange  = r_beat <= {1'b0, r_len};
    w_lastBeat = r_beat == {1'b0, r_len};
    w_sramWr   = w_wHs && w_inRange;
    w_nextAddr = r_fixed ? r_addr : r_addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
  end

  // Bus-facing outputs and SRAM port, derived from the registered state
  always_comb begin
    s_axi.ARREADY_S = w_grantRd;
    s_axi.AWREADY_S = w_grantWr;
    s_axi.WREADY_S  = w_wReady;
    s_axi.BVALID_S  = w_bValid;
    s_axi.BID_S     = ARESET ? '0 : r_id;
    s_axi.BRESP_S   = (w_bValid && r_err) ? 2'b10 : 2'b00;
    s_axi.RVALID_S  = w_rValid;
    s_axi.RDATA_S   = w_rValid ? sram_rdata : 32'h0;
    s_axi.RID_S     = ARESET ? '0 : r_id;
    s_axi.RRESP_S   = 2'b00;
    s_axi.RLAST_S   = w_rValid && w_lastBeat;
    sram_cs         = ((r_state == RD_REQ) && !ARESET) || w_sramWr;
    sram_we         = w_sramWr ? s_axi.WSTRB_S : 4'b0000;
    sram_addr       = r_addr;
    sram_wdata      = s_axi.WDATA_S;
  end

  // Size is always treated as word and address bits outside the SRAM window are ignored
  assign w_unused = &{1'b0, s_axi.ARSIZE_S, s_axi.AWSIZE_S,
                      s_axi.ARADDR_S[31:ADDR_BITS+2], s_axi.ARADDR_S[1:0],
                      s_axi.AWADDR_S[31:ADDR_BITS+2], s_axi.AWADDR_S[1:0]};

  // Transaction FSM: latches the granted request, walks the burst and tracks write errors
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state        <= IDLE;
      r_lastWasWrite <= 1'b1;
      r_fixed        <= 1'b0;
      r_err          <= 1'b0;
      r_id           <= '0;
      r_addr         <= '0;
      r_len          <= '0;
      r_beat         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantRd) begin
            r_id           <= s_axi.ARID_S;
            r_addr         <= s_axi.ARADDR_S[ADDR_BITS+1:2];
            r_len          <= s_axi.ARLEN_S;
            r_fixed        <= (s_axi.ARBURST_S == 2'b00);
            r_beat         <= '0;
            r_lastWasWrite <= 1'b0;
            r_state        <= RD_REQ;
          end else if (w_grantWr) begin
            r_id           <= s_axi.AWID_S;
            r_addr         <= s_axi.AWADDR_S[ADDR_BITS+1:2];
            r_len          <= s_axi.AWLEN_S;
            r_fixed        <= (s_axi.AWBURST_S == 2'b00);
            r_beat         <= '0;
            r_err          <= 1'b0;
            r_lastWasWrite <= 1'b1;
            r_state        <= WR_DATA;
          end
        end
        RD_REQ: begin
          r_state <= RD_DATA;
        end
        RD_DATA: begin
          if (s_axi.RREADY_S) begin
            if (w_lastBeat) begin
              r_state <= IDLE;
            end else begin
              r_beat  <= r_beat + 5'd1;
              r_addr  <= w_nextAddr;
              r_state <= RD_REQ;
            end
          end
        end
        WR_DATA: begin
          if (s_axi.WVALID_S) begin
            if (w_inRange) begin
              r_addr <= w_nextAddr;
            end
            if (!w_inRange || (s_axi.WLAST_S && !w_lastBeat)) begin
              r_err <= 1'b1;
            end
            if (r_beat != 5'd16) begin
              r_beat <= r_beat + 5'd1;
            end
            if (s_axi.WLAST_S) begin
              r_state <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (s_axi.BREADY_S) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: an SRAM model on the memory port and
// a word-array reference memory updated from the burst rules.
module tb_axi_sram_slave;
  localparam int ID_BITS   = 8;
  localparam int ADDR_BITS = 14;
  localparam int WORDS     = 16384;
  localparam int TMO       = 50;

  logic                 ACLK = 1'b0;
  logic                 ARESET;
  logic                 sram_cs;
  logic [3:0]           sram_we;
  logic [ADDR_BITS-1:0] sram_addr;
  logic [31:0]          sram_wdata;
  logic [31:0]          sram_rdata;

  axi_sram_slave_if #(.ID_BITS(ID_BITS)) bus ();

  axi_sram_slave #(.ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .s_axi      (bus),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  logic [31:0]          sramMem [0:WORDS-1];
  logic [31:0]          refMem  [0:WORDS-1];
  logic                 bdClear, bdWe;
  logic [ADDR_BITS-1:0] bdAddr;
  logic [31:0]          bdData;

  logic [31:0] wData [0:31];
  logic [3:0]  wStrb [0:31];
  logic [31:0] rData [0:15];
  logic        rLast [0:15];
  logic [7:0]  rIdSeen [0:15];
  logic [1:0]  rRespSeen [0:15];
  int          rLatency, wStalls;
  logic        rStable, rGapOk, bPrompt;
  logic [1:0]  bResp;
  logic [7:0]  bId;

  // Synchronous SRAM model with a backdoor for preloading and clearing
  always @(posedge ACLK) begin
    if (bdClear) begin
      for (int i = 0; i < WORDS; i++) sramMem[i] <= '0;
    end else if (bdWe) begin
      sramMem[bdAddr] <= bdData;
    end else if (sram_cs) begin
      if (sram_we == 4'b0000) sram_rdata <= sramMem[sram_addr];
      else for (int k = 0; k < 4; k++)
        if (sram_we[k]) sramMem[sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
    end
  end

  // Word touched by a given beat: FIXED stays put, anything else walks up and wraps
  function automatic int wordOf(logic [31:0] byteAddr, int beat, logic [1:0] burst);
    int w;
    w = int'(byteAddr[15:2]);
    if (burst != 2'b00) w = (w + beat) % WORDS;
    return w;
  endfunction

  // Applies a write burst to the reference memory and returns the expected response
  function automatic logic [1:0] refWrite(logic [31:0] addr, int len, logic [1:0] burst, int nBeats);
    int w;
    for (int b = 0; b < nBeats; b++) begin
      if (b <= len) begin
        w = wordOf(addr, b, burst);
        for (int k = 0; k < 4; k++)
          if (wStrb[b][k]) refMem[w][8*k +: 8] = wData[b][8*k +: 8];
      end
    end
    return (nBeats == len + 1) ? 2'b00 : 2'b10;
  endfunction

  task automatic idleBus();
    bus.ARID_S = '0; bus.ARADDR_S = '0; bus.ARLEN_S = '0; bus.ARSIZE_S = 3'b010;
    bus.ARBURST_S = 2'b01; bus.ARVALID_S = 1'b0;
    bus.AWID_S = '0; bus.AWADDR_S = '0; bus.AWLEN_S = '0; bus.AWSIZE_S = 3'b010;
    bus.AWBURST_S = 2'b01; bus.AWVALID_S = 1'b0;
    bus.WDATA_S = '0; bus.WSTRB_S = '0; bus.WLAST_S = 1'b0; bus.WVALID_S = 1'b0;
    bus.BREADY_S = 1'b0; bus.RREADY_S = 1'b0;
  endtask

  task automatic doReset();
    @(negedge ACLK);
    idleBus();
    ARESET = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic clearMem();
    @(negedge ACLK);
    bdClear = 1'b1;
    @(negedge ACLK);
    bdClear = 1'b0;
    for (int i = 0; i < WORDS; i++) refMem[i] = '0;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge ACLK);
    bdWe = 1'b1; bdAddr = idx[ADDR_BITS-1:0]; bdData = val;
    @(negedge ACLK);
    bdWe = 1'b0;
    refMem[idx] = val;
  endtask

  task automatic sendAr(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    int cnt;
    @(negedge ACLK);
    bus.ARID_S = id; bus.ARADDR_S = addr; bus.ARLEN_S = len; bus.ARBURST_S = burst;
    bus.ARSIZE_S = 3'($urandom_range(0, 7)); bus.ARVALID_S = 1'b1;
    #1; cnt = 0;
    while (bus.ARREADY_S !== 1'b1 && cnt < TMO) begin @(negedge ACLK); #1; cnt++; end
    checks++;
    if (cnt >= TMO) begin errors++; $display("[TB] FAIL ar_handshake: ARREADY_S low for %0d cycles, required high", cnt); end
    @(negedge ACLK);
    bus.ARVALID_S = 1'b0;
  endtask

  task automatic sendAw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    int cnt;
    @(negedge ACLK);
    bus.AWID_S = id; bus.AWADDR_S = addr; bus.AWLEN_S = len; bus.AWBURST_S = burst;
    bus.AWSIZE_S = 3'($urandom_range(0, 7)); bus.AWVALID_S = 1'b1;
    #1; cnt = 0;
    while (bus.AWREADY_S !== 1'b1 && cnt < TMO) begin @(negedge ACLK); #1; cnt++; end
    checks++;
    if (cnt >= TMO) begin errors++; $display("[TB] FAIL aw_handshake: AWREADY_S low for %0d cycles, required high", cnt); end
    @(negedge ACLK);
    bus.AWVALID_S = 1'b0;
  endtask

  task automatic doRead(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst, input bit toggle);
    int cnt;
    logic [31:0] held;
    rStable = 1'b1; rGapOk = 1'b1; rLatency = -1;
    bus.RREADY_S = 1'b0;
    sendAr(id, addr, len, burst);
    for (int b = 0; b <= int'(len); b++) begin
      bus.RREADY_S = !toggle;
      #1; cnt = 0;
      while (bus.RVALID_S !== 1'b1 && cnt < TMO) begin @(negedge ACLK); #1; cnt++; end
      checks++;
      if (cnt >= TMO) begin errors++; $display("[TB] FAIL r_wait: RVALID_S low for %0d cycles on beat %0d", cnt, b); end
      if (b == 0) rLatency = cnt + 1;
      else if (!toggle && cnt != 1) rGapOk = 1'b0;
      if (toggle) begin
        held = bus.RDATA_S;
        @(negedge ACLK); #1;
        if (bus.RVALID_S !== 1'b1 || bus.RDATA_S !== held) rStable = 1'b0;
        bus.RREADY_S = 1'b1;
        #1;
      end
      rData[b] = bus.RDATA_S; rLast[b] = bus.RLAST_S;
      rIdSeen[b] = bus.RID_S; rRespSeen[b] = bus.RRESP_S;
      @(negedge ACLK);
    end
    bus.RREADY_S = 1'b0;
  endtask

  task automatic doWrite(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst, input int nBeats);
    int cnt;
    wStalls = 0;
    sendAw(id, addr, len, burst);
    for (int b = 0; b < nBeats; b++) begin
      bus.WDATA_S = wData[b]; bus.WSTRB_S = wStrb[b];
      bus.WLAST_S = (b == nBeats - 1); bus.WVALID_S = 1'b1;
      #1; cnt = 0;
      while (bus.WREADY_S !== 1'b1 && cnt < TMO) begin @(negedge ACLK); #1; cnt++; end
      wStalls += cnt;
      checks++;
      if (cnt >= TMO) begin errors++; $display("[TB] FAIL w_wait: WREADY_S low for %0d cycles on beat %0d", cnt, b); end
      @(negedge ACLK);
    end
    bus.WVALID_S = 1'b0; bus.WLAST_S = 1'b0;
    #1;
    bPrompt = (bus.BVALID_S === 1'b1);
    bus.BREADY_S = 1'b1;
    cnt = 0;
    while (bus.BVALID_S !== 1'b1 && cnt < TMO) begin @(negedge ACLK); #1; cnt++; end
    checks++;
    if (cnt >= TMO) begin errors++; $display("[TB] FAIL b_wait: BVALID_S low for %0d cycles", cnt); end
    bResp = bus.BRESP_S; bId = bus.BID_S;
    @(negedge ACLK);
    bus.BREADY_S = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    bus.ARVALID_S = 1'b1; bus.AWVALID_S = 1'b1; bus.WVALID_S = 1'b1;
    bus.RREADY_S = 1'b1; bus.BREADY_S = 1'b1; bus.WSTRB_S = 4'hF;
    @(negedge ACLK); @(negedge ACLK); #1;
    checks++;
    if ({bus.ARREADY_S, bus.AWREADY_S, bus.WREADY_S, bus.RVALID_S, bus.BVALID_S} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_handshakes: got %b, required 00000", {bus.ARREADY_S, bus.AWREADY_S, bus.WREADY_S, bus.RVALID_S, bus.BVALID_S});
    end
    checks++;
    if ({sram_cs, sram_we} !== 5'b0) begin errors++; $display("[TB] FAIL reset_sram: got cs/we %b, required 00000", {sram_cs, sram_we}); end
    checks++;
    if ({bus.RDATA_S, bus.RID_S, bus.BID_S, bus.RRESP_S, bus.BRESP_S} !== '0) begin
      errors++; $display("[TB] FAIL reset_data: got rdata=%h rid=%h bid=%h rresp=%b bresp=%b, required all 0", bus.RDATA_S, bus.RID_S, bus.BID_S, bus.RRESP_S, bus.BRESP_S);
    end
    idleBus();
    @(negedge ACLK);
    ARESET = 1'b0;
    bus.AWVALID_S = 1'b1;
    #1;
    checks++;
    if ({bus.ARREADY_S, bus.AWREADY_S} !== 2'b01) begin errors++; $display("[TB] FAIL single_valid_grant: got ar/aw ready %b, required 01", {bus.ARREADY_S, bus.AWREADY_S}); end
    bus.AWVALID_S = 1'b0;
  endtask

  task automatic test_single_read();
    preload(4, 32'hDEADBEEF);
    doRead(8'h10, 32'h0000_0010, 4'd0, 2'b01, 1'b0);
    checks++;
    if (rLatency !== 2) begin errors++; $display("[TB] FAIL read_latency: got %0d cycles, required 2", rLatency); end
    checks++;
    if (rData[0] !== refMem[4]) begin errors++; $display("[TB] FAIL single_read_data: got %h, required %h", rData[0], refMem[4]); end
    checks++;
    if ({rIdSeen[0], rLast[0], rRespSeen[0]} !== {8'h10, 1'b1, 2'b00}) begin
      errors++; $display("[TB] FAIL single_read_meta: got rid=%h rlast=%b rresp=%b, required 10 1 00", rIdSeen[0], rLast[0], rRespSeen[0]);
    end
  endtask

  task automatic test_incr_write_read();
    logic [1:0] expResp;
    for (int b = 0; b < 4; b++) begin wData[b] = 32'(b + 1); wStrb[b] = 4'hF; end
    doWrite(8'h21, 32'h20, 4'd3, 2'b01, 4);
    expResp = refWrite(32'h20, 3, 2'b01, 4);
    checks++;
    if ({bResp, bId, bPrompt} !== {expResp, 8'h21, 1'b1}) begin
      errors++; $display("[TB] FAIL incr_write_resp: got bresp=%b bid=%h prompt=%b, required %b 21 1", bResp, bId, bPrompt, expResp);
    end
    checks++;
    if (wStalls !== 0) begin errors++; $display("[TB] FAIL write_throughput: got %0d stall cycles, required 0", wStalls); end
    for (int w = 8; w < 12; w++) begin
      checks++;
      if (sramMem[w] !== refMem[w]) begin errors++; $display("[TB] FAIL incr_write_mem[%0d]: got %h, required %h", w, sramMem[w], refMem[w]); end
    end
    for (int pass = 0; pass < 2; pass++) begin
      doRead(8'h22, 32'h20, 4'd3, 2'b01, pass == 1);
      for (int b = 0; b < 4; b++) begin
        checks++;
        if ({rData[b], rLast[b]} !== {refMem[8 + b], 1'(b == 3)}) begin
          errors++; $display("[TB] FAIL incr_read_beat%0d: got %h last=%b, required %h last=%b", b, rData[b], rLast[b], refMem[8 + b], b == 3);
        end
      end
      checks++;
      if ({rStable, rGapOk} !== 2'b11) begin errors++; $display("[TB] FAIL incr_read_timing: got stable=%b gap_ok=%b, required 11", rStable, rGapOk); end
    end
  endtask

  task automatic test_byte_strobe();
    logic [1:0] expResp;
    preload(5, 32'hFFFF_FFFF);
    wData[0] = 32'h1234_5678; wStrb[0] = 4'b0011;
    doWrite(8'h05, 32'h14, 4'd0, 2'b01, 1);
    expResp = refWrite(32'h14, 0, 2'b01, 1);
    doRead(8'h06, 32'h14, 4'd0, 2'b01, 1'b0);
    checks++;
    if ({rData[0], bResp} !== {refMem[5], expResp}) begin
      errors++; $display("[TB] FAIL byte_strobe: got %h bresp=%b, required %h bresp=%b", rData[0], bResp, refMem[5], expResp);
    end
  endtask

  task automatic test_arbitration();
    bit grantQ[$];
    logic [31:0] arbData;
    doReset();
    preload(16'h40, $urandom);
    arbData = $urandom;
    for (int c = 0; c < 30; c++) begin
      @(negedge ACLK);
      if (c == 0) begin
        bus.ARADDR_S = 32'h100; bus.ARLEN_S = 4'd0; bus.ARID_S = 8'hA1; bus.ARVALID_S = 1'b1;
        bus.AWADDR_S = 32'h200; bus.AWLEN_S = 4'd0; bus.AWID_S = 8'hB2; bus.AWVALID_S = 1'b1;
        bus.WDATA_S = arbData; bus.WSTRB_S = 4'hF; bus.WLAST_S = 1'b1; bus.WVALID_S = 1'b1;
        bus.RREADY_S = 1'b1; bus.BREADY_S = 1'b1;
      end
      #1;
      checks++;
      if (bus.ARREADY_S === 1'b1 && bus.AWREADY_S === 1'b1) begin errors++; $display("[TB] FAIL arb_exclusive: got both readies high in cycle %0d, required at most one", c); end
      if (bus.ARREADY_S === 1'b1) grantQ.push_back(1'b0);
      else if (bus.AWREADY_S === 1'b1) grantQ.push_back(1'b1);
      if (bus.RVALID_S === 1'b1) begin
        checks++;
        if (bus.RDATA_S !== refMem[16'h40]) begin errors++; $display("[TB] FAIL arb_read_data: got %h, required %h", bus.RDATA_S, refMem[16'h40]); end
      end
    end
    @(negedge ACLK);
    idleBus();
    refMem[16'h80] = arbData;
    checks++;
    if (grantQ.size() != 10) begin errors++; $display("[TB] FAIL arb_grant_count: got %0d grants, required 10", grantQ.size()); end
    for (int i = 0; i < grantQ.size(); i++) begin
      checks++;
      if (grantQ[i] !== 1'(i % 2)) begin errors++; $display("[TB] FAIL arb_order[%0d]: got %s, required %s", i, grantQ[i] ? "write" : "read", (i % 2) ? "write" : "read"); end
    end
    checks++;
    if (sramMem[16'h80] !== refMem[16'h80]) begin errors++; $display("[TB] FAIL arb_write_mem: got %h, required %h", sramMem[16'h80], refMem[16'h80]); end
  endtask

  task automatic test_wrap_fixed();
    logic [1:0] expResp;
    for (int b = 0; b < 3; b++) begin wData[b] = $urandom; wStrb[b] = 4'hF; end
    doWrite(8'h31, 32'h0000_FFFC, 4'd1, 2'b01, 2);
    expResp = refWrite(32'h0000_FFFC, 1, 2'b01, 2);
    checks++;
    if ({sramMem[16'h3FFF], sramMem[0], bResp} !== {refMem[16'h3FFF], refMem[0], expResp}) begin
      errors++; $display("[TB] FAIL incr_wrap: got %h %h bresp=%b, required %h %h bresp=%b", sramMem[16'h3FFF], sramMem[0], bResp, refMem[16'h3FFF], refMem[0], expResp);
    end
    for (int b = 0; b < 3; b++) wData[b] = $urandom;
    doWrite(8'h32, 32'h300, 4'd2, 2'b00, 3);
    expResp = refWrite(32'h300, 2, 2'b00, 3);
    checks++;
    if ({sramMem[16'hC0], sramMem[16'hC1], bResp} !== {refMem[16'hC0], refMem[16'hC1], expResp}) begin
      errors++; $display("[TB] FAIL fixed_write: got %h %h bresp=%b, required %h %h bresp=%b", sramMem[16'hC0], sramMem[16'hC1], bResp, refMem[16'hC0], refMem[16'hC1], expResp);
    end
    doRead(8'h33, 32'h300, 4'd2, 2'b00, 1'b0);
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (rData[b] !== refMem[16'hC0]) begin errors++; $display("[TB] FAIL fixed_read_beat%0d: got %h, required %h", b, rData[b], refMem[16'hC0]); end
    end
  endtask

  task automatic test_protocol_errors();
    logic [1:0] expResp;
    for (int b = 0; b < 4; b++) begin wData[b] = $urandom; wStrb[b] = 4'hF; end
    doWrite(8'h41, 32'h400, 4'd3, 2'b01, 2);
    expResp = refWrite(32'h400, 3, 2'b01, 2);
    checks++;
    if (bResp !== expResp) begin errors++; $display("[TB] FAIL early_wlast_resp: got %b, required %b", bResp, expResp); end
    for (int w = 16'h100; w < 16'h104; w++) begin
      checks++;
      if (sramMem[w] !== refMem[w]) begin errors++; $display("[TB] FAIL early_wlast_mem[%0h]: got %h, required %h", w, sramMem[w], refMem[w]); end
    end
    for (int b = 0; b < 3; b++) wData[b] = $urandom;
    doWrite(8'h42, 32'h500, 4'd0, 2'b01, 3);
    expResp = refWrite(32'h500, 0, 2'b01, 3);
    checks++;
    if (bResp !== expResp) begin errors++; $display("[TB] FAIL late_wlast_resp: got %b, required %b", bResp, expResp); end
    for (int w = 16'h140; w < 16'h143; w++) begin
      checks++;
      if (sramMem[w] !== refMem[w]) begin errors++; $display("[TB] FAIL late_wlast_mem[%0h]: got %h, required %h", w, sramMem[w], refMem[w]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int cnt;
    for (int w = 16'h180; w < 16'h184; w++) preload(w, $urandom);
    sendAr(8'h51, 32'h600, 4'd3, 2'b01);
    #1; cnt = 0;
    while (bus.RVALID_S !== 1'b1 && cnt < TMO) begin @(negedge ACLK); #1; cnt++; end
    ARESET = 1'b1;
    #1;
    checks++;
    if ({bus.RVALID_S, sram_cs, bus.RDATA_S, bus.RID_S} !== '0) begin
      errors++; $display("[TB] FAIL reset_during_read: got rvalid=%b cs=%b rdata=%h rid=%h, required all 0", bus.RVALID_S, sram_cs, bus.RDATA_S, bus.RID_S);
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    checks++;
    if (bus.RVALID_S !== 1'b0) begin errors++; $display("[TB] FAIL read_aborted: got RVALID_S=%b, required 0", bus.RVALID_S); end
    doRead(8'h52, 32'h600, 4'd3, 2'b01, 1'b0);
    checks++;
    if (rLatency !== 2) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d, required 2", rLatency); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({rData[b], rIdSeen[b]} !== {refMem[16'h180 + b], 8'h52}) begin
        errors++; $display("[TB] FAIL post_reset_read_beat%0d: got %h id=%h, required %h id=52", b, rData[b], rIdSeen[b], refMem[16'h180 + b]);
      end
    end
    for (int b = 0; b < 2; b++) begin wData[b] = $urandom | 32'h1; wStrb[b] = 4'hF; end
    sendAw(8'h53, 32'h700, 4'd3, 2'b01);
    bus.WDATA_S = wData[0]; bus.WSTRB_S = 4'hF; bus.WLAST_S = 1'b0; bus.WVALID_S = 1'b1;
    @(negedge ACLK);
    bus.WDATA_S = wData[1];
    ARESET = 1'b1;
    #1;
    checks++;
    if ({sram_cs, sram_we} !== 5'b0) begin errors++; $display("[TB] FAIL reset_during_write: got cs/we %b, required 00000", {sram_cs, sram_we}); end
    @(negedge ACLK);
    ARESET = 1'b0;
    idleBus();
    void'(refWrite(32'h700, 3, 2'b01, 1));
    #1;
    checks++;
    if (bus.BVALID_S !== 1'b0) begin errors++; $display("[TB] FAIL write_aborted: got BVALID_S=%b, required 0", bus.BVALID_S); end
    for (int w = 16'h1C0; w < 16'h1C4; w++) begin
      checks++;
      if (sramMem[w] !== refMem[w]) begin errors++; $display("[TB] FAIL aborted_write_mem[%0h]: got %h, required %h", w, sramMem[w], refMem[w]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst, expResp;
    logic [7:0]  id;
    int          word, nBeats;
    bit          toggle;
    for (int t = 0; t < 40; t++) begin
      word  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom_range(WORDS - 24, WORDS - 1);
      addr  = {16'($urandom), 14'(word), 2'($urandom)};
      len   = 4'($urandom);
      burst = 2'($urandom);
      id    = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        nBeats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 18) : int'(len) + 1;
        for (int b = 0; b < nBeats; b++) begin wData[b] = $urandom; wStrb[b] = 4'($urandom); end
        doWrite(id, addr, len, burst, nBeats);
        expResp = refWrite(addr, int'(len), burst, nBeats);
        checks++;
        if ({bResp, bId} !== {expResp, id}) begin
          errors++; $display("[TB] FAIL rand_write%0d: got bresp=%b bid=%h, required %b %h", t, bResp, bId, expResp, id);
        end
      end else begin
        toggle = 1'($urandom);
        doRead(id, addr, len, burst, toggle);
        for (int b = 0; b <= int'(len); b++) begin
          checks++;
          if ({rData[b], rLast[b], rIdSeen[b], rRespSeen[b]} !== {refMem[wordOf(addr, b, burst)], 1'(b == int'(len)), id, 2'b00}) begin
            errors++; $display("[TB] FAIL rand_read%0d_beat%0d: got %h last=%b id=%h resp=%b, required %h last=%b id=%h resp=00",
              t, b, rData[b], rLast[b], rIdSeen[b], rRespSeen[b], refMem[wordOf(addr, b, burst)], b == int'(len), id);
          end
        end
        checks++;
        if (rStable !== 1'b1) begin errors++; $display("[TB] FAIL rand_read%0d_stable: got %b, required 1", t, rStable); end
      end
    end
  endtask

  // Test sequence
  initial begin
    ARESET = 1'b1;
    bdClear = 1'b0; bdWe = 1'b0; bdAddr = '0; bdData = '0;
    idleBus();
    test_reset();
    clearMem();
    test_single_read();
    test_incr_write_read();
    test_byte_strobe();
    test_arbitration();
    test_wrap_fixed();
    test_protocol_errors();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
